// File: rtl/mr1_mem_arbiter_if.sv
// Bus bundle between the MR1 core's fetch/data ports, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the core-plus-memory environment.
interface mr1_mem_arbiter_if;
  logic        instr_req_valid;
  logic        instr_req_ready;
  logic [31:0] instr_req_addr;
  logic        instr_rsp_valid;
  logic [31:0] instr_rsp_data;

  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wr;
  logic [1:0]  data_req_size;
  logic [31:0] data_req_addr;
  logic [31:0] data_req_data;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wr;
  logic [1:0]  mem_req_size;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  modport slave (
    input  instr_req_valid, instr_req_addr,
    output instr_req_ready, instr_rsp_valid, instr_rsp_data,
    input  data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    output data_req_ready, data_rsp_valid, data_rsp_data,
    output mem_req_valid, mem_req_wr, mem_req_size, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport master (
    output instr_req_valid, instr_req_addr,
    input  instr_req_ready, instr_rsp_valid, instr_rsp_data,
    output data_req_valid, data_req_wr, data_req_size, data_req_addr, data_req_data,
    input  data_req_ready, data_rsp_valid, data_rsp_data,
    input  mem_req_valid, mem_req_wr, mem_req_size, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/mr1_mem_arbiter.sv
// Merges MR1 fetch and data requests onto one memory port; in-order responses are routed
// back through a source-tag FIFO. Define MR1_MEM_ARB_RR_EN for round-robin arbitration.
module mr1_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  mr1_mem_arbiter_if.slave    bus,
  output logic                rsp_err
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_t;

  state_t          state;
  logic            tags [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic prefer_data;
  logic pick_data;
  logic sel_valid;
  logic sel_wr;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic stall;
  logic blocked;
  logic handshake;
  logic head_tag;

`ifdef MR1_MEM_ARB_RR_EN
  // Remembers whether data won the last handshake; the other source goes first next conflict.
  logic last_data;

  always_ff @(posedge clk) begin
    if (reset)          last_data <= 1'b0;
    else if (handshake) last_data <= pick_data;
  end

  assign prefer_data = !last_data;
`else
  assign prefer_data = 1'b1;
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    pick_data = 1'b0;
    case (state)
      IDLE:    pick_data = bus.data_req_valid && (!bus.instr_req_valid || prefer_data);
      HOLD_I:  pick_data = 1'b0;
      HOLD_D:  pick_data = 1'b1;
      default: pick_data = 1'b0;
    endcase
  end

  assign sel_valid  = pick_data ? bus.data_req_valid : bus.instr_req_valid;
  assign sel_wr     = pick_data && bus.data_req_wr;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_COUNT);
  assign pop        = !reset && bus.mem_rsp_valid && !fifo_empty;
  assign stall      = fifo_full && !pop;
  // Writes never wait on the tag FIFO; reads are withheld from memory while it is full.
  assign blocked    = stall && !sel_wr;

  assign bus.mem_req_valid  = !reset && sel_valid && !blocked;
  assign handshake          = bus.mem_req_valid && bus.mem_req_ready;
  assign push               = handshake && !sel_wr;

  assign bus.mem_req_wr     = sel_wr;
  assign bus.mem_req_size   = pick_data ? bus.data_req_size : 2'd2;
  assign bus.mem_req_addr   = pick_data ? bus.data_req_addr : bus.instr_req_addr;
  assign bus.mem_req_data   = pick_data ? bus.data_req_data : 32'h0;

  assign bus.instr_req_ready = handshake && !pick_data;
  assign bus.data_req_ready  = handshake && pick_data;

  assign head_tag            = tags[rd_ptr];
  assign bus.instr_rsp_valid = pop && !head_tag;
  assign bus.data_rsp_valid  = pop && head_tag;
  assign bus.instr_rsp_data  = bus.mem_rsp_data;
  assign bus.data_rsp_data   = bus.mem_rsp_data;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (sel_valid && !handshake) state <= pick_data ? HOLD_D : HOLD_I;
        HOLD_I,
        HOLD_D:  if (handshake) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag storage has no reset; pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) tags[wr_ptr] <= pick_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.mem_rsp_valid && fifo_empty) rsp_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// Directed bench for mr1_mem_arbiter: inputs change on the falling edge, outputs are
// compared 1 ns later, and expected values are hand-computed constants.
module tb_mr1_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic rsp_err;
  int   vectors = 0;
  int   miscompares = 0;

  mr1_mem_arbiter_if bus();

  mr1_mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .rsp_err (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    bus.instr_req_valid = 1'b0;
    bus.instr_req_addr  = 32'h0;
    bus.data_req_valid  = 1'b0;
    bus.data_req_wr     = 1'b0;
    bus.data_req_size   = 2'd2;
    bus.data_req_addr   = 32'h0;
    bus.data_req_data   = 32'h0;
    bus.mem_req_ready   = 1'b1;
    bus.mem_rsp_valid   = 1'b0;
    bus.mem_rsp_data    = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.instr_req_valid = 1'b1;
    bus.data_req_valid  = 1'b1;
    bus.mem_rsp_valid   = 1'b1;
    #1;
    vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req_valid: got %b want 0", bus.mem_req_valid); end
    vectors++; if (bus.instr_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_instr_req_ready: got %b want 0", bus.instr_req_ready); end
    vectors++; if (bus.data_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_data_req_ready: got %b want 0", bus.data_req_ready); end
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 00", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL idle_mem_req_valid: got %b want 0", bus.mem_req_valid); end
  endtask

  task automatic test_instr_read();
    @(negedge clk);
    bus.instr_req_valid = 1'b1;
    bus.instr_req_addr  = 32'h100;
    #1;
    vectors++; if (bus.mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL ird_mem_req_valid: got %b want 1", bus.mem_req_valid); end
    vectors++; if (bus.mem_req_addr !== 32'h100) begin miscompares++; $display("FAIL ird_mem_req_addr: got %h want 00000100", bus.mem_req_addr); end
    vectors++; if (bus.mem_req_wr !== 1'b0) begin miscompares++; $display("FAIL ird_mem_req_wr: got %b want 0", bus.mem_req_wr); end
    vectors++; if ({bus.instr_req_ready, bus.data_req_ready} !== 2'b10) begin miscompares++; $display("FAIL ird_ready: got %b want 10", {bus.instr_req_ready, bus.data_req_ready}); end
    @(negedge clk);
    bus.instr_req_valid = 1'b0;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h0000_0013;
    #1;
    vectors++; if (bus.instr_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL ird_instr_rsp_valid: got %b want 1", bus.instr_rsp_valid); end
    vectors++; if (bus.instr_rsp_data !== 32'h0000_0013) begin miscompares++; $display("FAIL ird_instr_rsp_data: got %h want 00000013", bus.instr_rsp_data); end
    vectors++; if (bus.data_rsp_valid !== 1'b0) begin miscompares++; $display("FAIL ird_data_rsp_valid: got %b want 0", bus.data_rsp_valid); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_conflict();
    @(negedge clk);
    bus.instr_req_valid = 1'b1;
    bus.instr_req_addr  = 32'h400;
    bus.data_req_valid  = 1'b1;
    bus.data_req_addr   = 32'h800;
    #1;
    vectors++; if (bus.mem_req_addr !== 32'h800) begin miscompares++; $display("FAIL conf_first_addr: got %h want 00000800", bus.mem_req_addr); end
    vectors++; if ({bus.instr_req_ready, bus.data_req_ready} !== 2'b01) begin miscompares++; $display("FAIL conf_first_ready: got %b want 01", {bus.instr_req_ready, bus.data_req_ready}); end
    @(negedge clk);
    bus.data_req_valid = 1'b0;
    #1;
    vectors++; if (bus.mem_req_addr !== 32'h400) begin miscompares++; $display("FAIL conf_second_addr: got %h want 00000400", bus.mem_req_addr); end
    vectors++; if ({bus.instr_req_ready, bus.data_req_ready} !== 2'b10) begin miscompares++; $display("FAIL conf_second_ready: got %b want 10", {bus.instr_req_ready, bus.data_req_ready}); end
    @(negedge clk);
    bus.instr_req_valid = 1'b0;
    bus.mem_rsp_valid   = 1'b1;
    bus.mem_rsp_data    = 32'hAAAA_0000;
    #1;
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b01) begin miscompares++; $display("FAIL conf_rsp0_route: got %b want 01", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    vectors++; if (bus.data_rsp_data !== 32'hAAAA_0000) begin miscompares++; $display("FAIL conf_rsp0_data: got %h want aaaa0000", bus.data_rsp_data); end
    @(negedge clk);
    bus.mem_rsp_data = 32'h5555_FFFF;
    #1;
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL conf_rsp1_route: got %b want 10", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    vectors++; if (bus.instr_rsp_data !== 32'h5555_FFFF) begin miscompares++; $display("FAIL conf_rsp1_data: got %h want 5555ffff", bus.instr_rsp_data); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Data issues two reads back to back while instr waits: the second conflict decides the policy.
  task automatic test_back_to_back();
`ifdef MR1_MEM_ARB_RR_EN
    logic second_data = 1'b0;
`else
    logic second_data = 1'b1;
`endif
    logic [31:0] second_addr;
    logic [31:0] third_addr;
    logic        route [3];
    second_addr = second_data ? 32'h808 : 32'h404;
    third_addr  = second_data ? 32'h404 : 32'h808;
    route[0] = 1'b1;
    route[1] = second_data;
    route[2] = !second_data;
    @(negedge clk);
    bus.instr_req_valid = 1'b1;
    bus.instr_req_addr  = 32'h404;
    bus.data_req_valid  = 1'b1;
    bus.data_req_addr   = 32'h804;
    #1;
    vectors++; if (bus.mem_req_addr !== 32'h804) begin miscompares++; $display("FAIL b2b_first_addr: got %h want 00000804", bus.mem_req_addr); end
    @(negedge clk);
    bus.data_req_addr = 32'h808;
    #1;
    vectors++; if (bus.mem_req_addr !== second_addr) begin miscompares++; $display("FAIL b2b_second_addr: got %h want %h", bus.mem_req_addr, second_addr); end
    vectors++; if (bus.data_req_ready !== second_data) begin miscompares++; $display("FAIL b2b_second_ready: got %b want %b", bus.data_req_ready, second_data); end
    @(negedge clk);
    if (second_data) bus.data_req_valid = 1'b0;
    else             bus.instr_req_valid = 1'b0;
    #1;
    vectors++; if (bus.mem_req_addr !== third_addr) begin miscompares++; $display("FAIL b2b_third_addr: got %h want %h", bus.mem_req_addr, third_addr); end
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'h10 + 32'(i);
      #1;
      vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== {!route[i], route[i]}) begin miscompares++; $display("FAIL b2b_rsp%0d_route: got %b want %b", i, {bus.instr_rsp_valid, bus.data_rsp_valid}, {!route[i], route[i]}); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  // Instr is parked by a busy memory; a data request arriving later must not steal the grant.
  task automatic test_hold();
    @(negedge clk);
    bus.mem_req_ready   = 1'b0;
    bus.instr_req_valid = 1'b1;
    bus.instr_req_addr  = 32'h500;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (bus.mem_req_addr !== 32'h500 || bus.mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL hold_addr_c%0d: got %h/%b want 00000500/1", i, bus.mem_req_addr, bus.mem_req_valid); end
      vectors++; if ({bus.instr_req_ready, bus.data_req_ready} !== 2'b00) begin miscompares++; $display("FAIL hold_ready_c%0d: got %b want 00", i, {bus.instr_req_ready, bus.data_req_ready}); end
      @(negedge clk);
      bus.data_req_valid = 1'b1;
      bus.data_req_addr  = 32'h900;
    end
    bus.mem_req_ready = 1'b1;
    #1;
    vectors++; if (bus.mem_req_addr !== 32'h500) begin miscompares++; $display("FAIL hold_release_addr: got %h want 00000500", bus.mem_req_addr); end
    vectors++; if ({bus.instr_req_ready, bus.data_req_ready} !== 2'b10) begin miscompares++; $display("FAIL hold_release_ready: got %b want 10", {bus.instr_req_ready, bus.data_req_ready}); end
    @(negedge clk);
    bus.instr_req_valid = 1'b0;
    #1;
    vectors++; if (bus.mem_req_addr !== 32'h900 || bus.data_req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_next_grant: got %h/%b want 00000900/1", bus.mem_req_addr, bus.data_req_ready); end
    @(negedge clk);
    clear_inputs();
    bus.mem_rsp_valid = 1'b1;
    #1;
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b10) begin miscompares++; $display("FAIL hold_rsp0_route: got %b want 10", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    @(negedge clk);
    #1;
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b01) begin miscompares++; $display("FAIL hold_rsp1_route: got %b want 01", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.data_req_valid = 1'b1;
    bus.data_req_wr    = 1'b1;
    bus.data_req_size  = 2'd0;
    bus.data_req_addr  = 32'h203;
    bus.data_req_data  = 32'hEF;
    #1;
    vectors++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_wr !== 1'b1) begin miscompares++; $display("FAIL st_valid_wr: got %b/%b want 1/1", bus.mem_req_valid, bus.mem_req_wr); end
    vectors++; if (bus.mem_req_size !== 2'd0) begin miscompares++; $display("FAIL st_size: got %0d want 0", bus.mem_req_size); end
    vectors++; if (bus.mem_req_addr !== 32'h203 || bus.mem_req_data !== 32'hEF) begin miscompares++; $display("FAIL st_addr_data: got %h/%h want 00000203/000000ef", bus.mem_req_addr, bus.mem_req_data); end
    vectors++; if (bus.data_req_ready !== 1'b1) begin miscompares++; $display("FAIL st_ready: got %b want 1", bus.data_req_ready); end
    @(negedge clk);
    clear_inputs();
    #1;
    vectors++; if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL st_single_req: got %b want 0", bus.mem_req_valid); end
  endtask

  // Runs right after the store, so a stray tag from the write would show up as a routed response.
  task automatic test_rsp_err();
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL err_before: got %b want 0", rsp_err); end
    @(negedge clk);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hDEAD;
    #1;
    vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL err_no_route: got %b want 00", {bus.instr_rsp_valid, bus.data_rsp_valid}); end
    @(negedge clk);
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (rsp_err !== 1'b1) begin miscompares++; $display("FAIL err_sticky_c%0d: got %b want 1", i, rsp_err); end
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL err_cleared: got %b want 0", rsp_err); end
  endtask

  task automatic test_full();
    logic        route [6];
    logic [31:0] rdata [6];
    route = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rdata = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.instr_req_valid = 1'b1;
      bus.instr_req_addr  = 32'h600 + 32'(4 * i);
      #1;
      vectors++; if (bus.instr_req_ready !== 1'b1) begin miscompares++; $display("FAIL full_fill%0d_ready: got %b want 1", i, bus.instr_req_ready); end
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.instr_req_valid = 1'b0;
      bus.data_req_valid  = 1'b1;
      bus.data_req_addr   = 32'hA00 + 32'(4 * k);
      #1;
      vectors++; if (bus.data_req_ready !== 1'b0) begin miscompares++; $display("FAIL full_stall%0d_ready: got %b want 0", k, bus.data_req_ready); end
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rdata[k];
      #1;
      vectors++; if (bus.data_req_ready !== 1'b1) begin miscompares++; $display("FAIL full_pushpop%0d_ready: got %b want 1", k, bus.data_req_ready); end
      vectors++; if (bus.instr_rsp_valid !== 1'b1 || bus.instr_rsp_data !== rdata[k]) begin miscompares++; $display("FAIL full_pushpop%0d_rsp: got %b/%h want 1/%h", k, bus.instr_rsp_valid, bus.instr_rsp_data, rdata[k]); end
      @(negedge clk);
      clear_inputs();
    end
    for (int i = 2; i < 6; i++) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = rdata[i];
      #1;
      vectors++; if ({bus.instr_rsp_valid, bus.data_rsp_valid} !== {!route[i], route[i]}) begin miscompares++; $display("FAIL full_drain%0d_route: got %b want %b", i, {bus.instr_rsp_valid, bus.data_rsp_valid}, {!route[i], route[i]}); end
      @(negedge clk);
    end
    clear_inputs();
    #1;
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL full_no_err: got %b want 0", rsp_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_instr_read();
    test_conflict();
    test_back_to_back();
    test_hold();
    test_store();
    test_rsp_err();
    test_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
